fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 4-bit core, directly upstream of the instruction decoder. The block owns the fetch PC and issues single-outstanding read requests to the instruction memory. It buffers returned 8-bit instructions and presents them to the decoder with a valid/ready handshake. Taken branches, resolved downstream, redirect the fetch PC and flush anything fetched down the wrong path.

## Interface
Parameters:
- `PC_LEN`, 7: fetch address width (128-instruction space).
- `INSTR_LEN`, 8: instruction width.

Ports:
- `CLK`  in  1  the only clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `IMEM_REQ`  out  1  read request, registered.
- `IMEM_ADDR`  out  PC_LEN  read address, registered, valid while `IMEM_REQ`=1.
- `IMEM_READY`  in  1  memory accepts the request on a cycle with `IMEM_REQ`=1 and `IMEM_READY`=1.
- `IMEM_RVALID`  in  1  read data valid, at least 1 cycle after acceptance.
- `IMEM_RDATA`  in  INSTR_LEN  read data.
- `INSTR`  out  INSTR_LEN  head-of-buffer instruction, to the decoder.
- `INSTR_PC`  out  PC_LEN  address of `INSTR`.
- `INSTR_VALID`  out  1  `INSTR` and `INSTR_PC` are valid.
- `DEC_READY`  in  1  the decoder consumes the head on `INSTR_VALID`&`DEC_READY`.
- `BR_TAKEN`  in  1  single-cycle redirect pulse.
- `BR_TARGET`  in  PC_LEN  redirect address, sampled with `BR_TAKEN`.

## Operation
- Buffer: FIFO of {instr, pc}. Depth is `DEPTH` (see Configuration). `INSTR`/`INSTR_PC` are driven from the head entry.
- Fetch PC `fpc` increments by 1 on each accepted request and wraps from 127 to 0.
- At most one request is outstanding at any time.
- FSM states:
  - IDLE: reset state. Moves to REQ on the first edge after reset release.
  - REQ: `IMEM_REQ`=1 with `IMEM_ADDR`=`fpc`. On accept, moves to WAIT.
  - WAIT: waits for `IMEM_RVALID`. On RVALID, pushes {RDATA, addr}. If space remains after push/pop, moves to REQ; otherwise moves to HOLD.
  - HOLD: no request issued. Moves to REQ when occupancy after the pop is below `DEPTH`.
  - DROP: waits for a stale response, discards it, then moves to REQ.
- A request is issued (entry to REQ) only when occupancy after the same-cycle pop is below `DEPTH`. This guarantees every response has a slot.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- Branch handling: `BR_TAKEN`=1 at an edge applies all of the following.
  - The buffer is flushed, and the flush overrides a same-cycle pop or push.
  - `fpc` is loaded with `BR_TARGET`.
  - In REQ without accept, the request is withdrawn and reissued next cycle at `BR_TARGET`.
  - In REQ with accept, or in WAIT without RVALID, the FSM moves to DROP.
  - In WAIT with RVALID, the data is discarded and the FSM moves to REQ.
  - In IDLE, HOLD or DROP, the FSM moves to REQ (from DROP only if RVALID is present this cycle; otherwise it stays in DROP).
- Any `RDATA` received in DROP is never visible on `INSTR`.

## Timing
- Reset values: `IMEM_REQ`=0, `IMEM_ADDR`=0, `INSTR`=8'h00, `INSTR_PC`=0, `INSTR_VALID`=0, `fpc`=0, buffer empty, state IDLE.
- If `RST_N` is asserted mid-transaction, all state clears immediately. A response arriving after reset release and before the first request is ignored.
- First request: `IMEM_REQ`=1 at the second edge after reset release (IDLE→REQ, then the registered output).
- Response latency: an instruction received with RVALID at edge n has `INSTR_VALID`=1 after edge n.
- Throughput with a zero-wait memory (READY=1, RVALID 1 cycle after accept): one instruction per 2 cycles.
- Branch penalty: the new request is visible on `IMEM_REQ` one cycle after the `BR_TAKEN` edge, plus the DROP wait when a response is in flight.
- `BR_TAKEN` takes priority over every other event in the same cycle.

## Configuration
- `FETCH_PREFETCH_EN` defined: `DEPTH`=2. Fetch continues while the decoder stalls, so up to 2 instructions are buffered.
- Not defined: `DEPTH`=1. The next request is issued only once the buffer is empty or being popped that cycle, with no fetch-ahead. The interface and FSM are unchanged.

## Test plan
- Reset, zero-wait memory returning `RDATA`=addr^8'hA5, `DEC_READY`=1 → `INSTR_PC` sequence 0,1,2,… with `INSTR`=8'hA5,8'hA4,…; first `IMEM_REQ` 2 cycles after release.
- Hold `DEC_READY`=0 for 10 cycles → with the macro, exactly 2 requests issued and the FSM in HOLD; without it, exactly 1. Releasing `DEC_READY` drains the buffer in order with no loss or duplication.
- `BR_TAKEN`=1, `BR_TARGET`=7'h40 while in WAIT, with the response arriving 3 cycles later → response dropped, next `IMEM_ADDR`=7'h40, `INSTR_VALID` stays 0 until the 7'h40 data returns.
- `BR_TAKEN` in the same cycle as RVALID and `DEC_READY` with 2 entries buffered → buffer empty, data discarded, FSM in REQ at `BR_TARGET`.
- Start at `BR_TARGET`=7'h7E → addresses 7E, 7F, 00, 01 are fetched (wrap-around).
- Assert `RST_N`=0 in WAIT, then deliver RVALID 1 cycle after release → the response is ignored, `INSTR_VALID`=0, and the first request goes to address 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 4-bit core.
// Owns the fetch PC, issues one outstanding read at a time to instruction
// memory, buffers returned instructions and hands them to the decoder over a
// valid/ready handshake. Taken branches redirect the PC and flush the buffer.
//
// Build option: define FETCH_PREFETCH_EN for a 2-entry buffer that keeps
// fetching while the decoder stalls; otherwise the buffer holds 1 entry and
// the next fetch waits until that entry is being consumed.
module fetch_unit #(
  parameter int PC_LEN    = 7,
  parameter int INSTR_LEN = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  output logic                 IMEM_REQ,
  output logic [PC_LEN-1:0]    IMEM_ADDR,
  input  logic                 IMEM_READY,
  input  logic                 IMEM_RVALID,
  input  logic [INSTR_LEN-1:0] IMEM_RDATA,
  output logic [INSTR_LEN-1:0] INSTR,
  output logic [PC_LEN-1:0]    INSTR_PC,
  output logic                 INSTR_VALID,
  input  logic                 DEC_READY,
  input  logic                 BR_TAKEN,
  input  logic [PC_LEN-1:0]    BR_TARGET
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);            // occupancy width
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // entry index width

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t                state, state_next;
  logic                  req_q, req_next;
  logic [PC_LEN-1:0]     fpc;
  logic [PC_LEN-1:0]     out_addr;   // address of the request in flight
  logic [CW-1:0]         count;
  logic [INSTR_LEN-1:0]  buf_instr [DEPTH];
  logic [PC_LEN-1:0]     buf_pc    [DEPTH];

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         occ_after_pop;
  logic [CW-1:0]         occ_next;
  logic [IW-1:0]         wr_idx;

  assign accept        = req_q & IMEM_READY;
  assign pop           = (count != '0) & DEC_READY & ~BR_TAKEN;
  assign push          = (state == S_WAIT) & IMEM_RVALID & ~BR_TAKEN;
  assign occ_after_pop = count - CW'(pop);
  assign occ_next      = occ_after_pop + CW'(push);
  assign wr_idx        = IW'(occ_after_pop);

  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = fpc;
  assign INSTR       = buf_instr[0];
  assign INSTR_PC    = buf_pc[0];
  assign INSTR_VALID = (count != '0);

  // Next-state and next-request decode; a branch overrides every other event.
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path through the case statement leaves a value held, which would infer a latch.
    state_next = state;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (BR_TAKEN)    state_next = accept ? S_DROP : S_REQ;
        else if (accept) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (BR_TAKEN)         state_next = IMEM_RVALID ? S_REQ : S_DROP;
        else if (IMEM_RVALID) state_next = (occ_next < CW'(DEPTH)) ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (BR_TAKEN || (occ_after_pop < CW'(DEPTH))) state_next = S_REQ;
      end
      S_DROP: begin
        if (IMEM_RVALID) state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
    // Entering REQ from IDLE or through a branch costs one cycle with the
    // request line low, so the address is settled before it is presented.
    req_next = (state_next == S_REQ) && !BR_TAKEN && (state != S_IDLE);
  end

  // FSM state, request line, fetch PC and in-flight address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      req_q    <= 1'b0;
      fpc      <= '0;
      out_addr <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
      req_q <= req_next;
      if (accept) out_addr <= fpc;
      if (BR_TAKEN)    fpc <= BR_TARGET;
      else if (accept) fpc <= fpc + 1'b1;
    end
  end

  // Instruction buffer: head at entry 0, pop shifts down, push fills the
  // first free slot after the pop; a branch flushes everything.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
      // NOTE: the storage entries are reset too, because entry 0 drives
      // INSTR/INSTR_PC and those outputs have defined reset values.
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (BR_TAKEN) begin
      count <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          buf_instr[i] <= buf_instr[i+1];
          buf_pc[i]    <= buf_pc[i+1];
        end
      end
      if (push) begin
        buf_instr[wr_idx] <= IMEM_RDATA;
        buf_pc[wr_idx]    <= out_addr;
      end
      count <= occ_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: memory model answering RDATA = addr ^ 8'hA5,
// table of branch-start vectors plus directed multi-cycle sequences.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       CLK, RST_N;
  logic       IMEM_REQ, IMEM_READY, IMEM_RVALID;
  logic [6:0] IMEM_ADDR;
  logic [7:0] IMEM_RDATA;
  logic [7:0] INSTR;
  logic [6:0] INSTR_PC;
  logic       INSTR_VALID, DEC_READY, BR_TAKEN;
  logic [6:0] BR_TARGET;

  fetch_unit #(.PC_LEN(7), .INSTR_LEN(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_READY(IMEM_READY),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .INSTR(INSTR), .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID),
    .DEC_READY(DEC_READY), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: accepts on REQ&READY, answers after mem_lat edges.
  int   mem_lat = 1;
  bit   mem_en  = 1'b1;
  bit   pend    = 1'b0;
  int   cnt     = 0;
  logic [6:0] paddr = '0;

  initial begin
    logic acc;
    logic [6:0] aa;
    forever begin
      @(posedge CLK);
      acc = IMEM_REQ && IMEM_READY && RST_N;
      aa  = IMEM_ADDR;
      #1;
      if (!mem_en || !RST_N) begin
        pend = 1'b0;
        if (mem_en) IMEM_RVALID = 1'b0;
      end else begin
        IMEM_RVALID = 1'b0;
        if (acc) begin
          pend  = 1'b1;
          paddr = aa;
          cnt   = mem_lat;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = paddr ^ 8'hA5;
            pend        = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: logs accepted addresses and decoder pops {pc, instr}.
  int          acc_cnt = 0;
  logic [14:0] pop_q[$];

  initial begin
    forever begin
      @(posedge CLK);
      if (RST_N) begin
        if (IMEM_REQ && IMEM_READY) acc_cnt++;
        if (INSTR_VALID && DEC_READY && !BR_TAKEN) pop_q.push_back({INSTR_PC, INSTR});
      end
    end
  end

  // Bench drives and samples 3 time units after each rising edge.
  task automatic tick();
    @(posedge CLK);
    #3;
  endtask

  task automatic do_reset(input logic dec_rdy);
    RST_N     = 1'b0;
    BR_TAKEN  = 1'b0;
    DEC_READY = dec_rdy;
    tick();
    tick();
    RST_N = 1'b1;
    pop_q.delete();
    acc_cnt = 0;
  endtask

  task automatic branch(input logic [6:0] tgt);
    BR_TAKEN  = 1'b1;
    BR_TARGET = tgt;
    tick();
    BR_TAKEN = 1'b0;
    pop_q.delete();
    acc_cnt = 0;
  endtask

  task automatic wait_pops(input string name, input int n);
    int k;
    k = 0;
    while (pop_q.size() < n && k < 80) begin
      tick();
      k++;
    end
    if (pop_q.size() < n) check({name, "_timeout"}, pop_q.size(), n);
  endtask

  task automatic wait_accept(input string name);
    int k;
    k = 0;
    while (!(IMEM_REQ && IMEM_READY) && k < 30) begin
      tick();
      k++;
    end
    if (!(IMEM_REQ && IMEM_READY)) check({name, "_no_req"}, 0, 1);
    tick();  // acceptance edge; FSM now in WAIT
  endtask

  typedef struct {
    logic [6:0]      start;
    logic [0:3][6:0] pc;
    logic [0:3][7:0] instr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int   k;
    bit   early_valid;

    vecs[0] = '{start: 7'h00, pc: '{7'h00, 7'h01, 7'h02, 7'h03}, instr: '{8'hA5, 8'hA4, 8'hA7, 8'hA6}};
    vecs[1] = '{start: 7'h7E, pc: '{7'h7E, 7'h7F, 7'h00, 7'h01}, instr: '{8'hDB, 8'hDA, 8'hA5, 8'hA4}};
    vecs[2] = '{start: 7'h40, pc: '{7'h40, 7'h41, 7'h42, 7'h43}, instr: '{8'hE5, 8'hE4, 8'hE7, 8'hE6}};
    vecs[3] = '{start: 7'h13, pc: '{7'h13, 7'h14, 7'h15, 7'h16}, instr: '{8'hB6, 8'hB1, 8'hB0, 8'hB3}};

    RST_N = 1'b0; IMEM_READY = 1'b1; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
    DEC_READY = 1'b1; BR_TAKEN = 1'b0; BR_TARGET = '0;

    // ---- reset values and first-request latency ----
    tick();
    check("rst_req",   IMEM_REQ, 0);
    check("rst_addr",  IMEM_ADDR, 0);
    check("rst_instr", INSTR, 8'h00);
    check("rst_pc",    INSTR_PC, 0);
    check("rst_valid", INSTR_VALID, 0);
    do_reset(1'b1);
    tick();
    check("first_req_edge1", IMEM_REQ, 0);
    tick();
    check("first_req_edge2", IMEM_REQ, 1);
    check("first_req_addr",  IMEM_ADDR, 0);

    // ---- streaming from reset ----
    wait_pops("stream", 6);
    for (int i = 0; i < 6; i++) begin
      if (i < pop_q.size()) begin
        check($sformatf("stream_pc%0d", i),    pop_q[i][14:8], i);
        check($sformatf("stream_instr%0d", i), pop_q[i][7:0],  i ^ 8'hA5);
      end
    end

    // ---- table: branch to each start address, check next 4 pops ----
    for (int v = 0; v < 4; v++) begin
      branch(vecs[v].start);
      wait_pops($sformatf("vec%0d", v), 4);
      for (int i = 0; i < 4; i++) begin
        if (i < pop_q.size()) begin
          check($sformatf("vec%0d_pc%0d", v, i),    pop_q[i][14:8], vecs[v].pc[i]);
          check($sformatf("vec%0d_instr%0d", v, i), pop_q[i][7:0],  vecs[v].instr[i]);
        end
      end
    end

    // ---- decoder stall: DEPTH requests, then in-order drain ----
    do_reset(1'b0);
    for (int i = 0; i < 14; i++) tick();
    check("stall_reqs",  acc_cnt, DEPTH);
    check("stall_noreq", IMEM_REQ, 0);
    check("stall_valid", INSTR_VALID, 1);
    check("stall_head",  INSTR_PC, 0);
    DEC_READY = 1'b1;
    wait_pops("drain", 4);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_q.size()) begin
        check($sformatf("drain_pc%0d", i),    pop_q[i][14:8], i);
        check($sformatf("drain_instr%0d", i), pop_q[i][7:0],  i ^ 8'hA5);
      end
    end

    // ---- branch in WAIT, response 3 cycles after accept is dropped ----
    mem_lat = 3;
    do_reset(1'b1);
    wait_accept("drop");
    branch(7'h40);
    check("drop_req_low", IMEM_REQ, 0);
    early_valid = 1'b0;
    k = 0;
    while (!IMEM_REQ && k < 20) begin
      if (INSTR_VALID) early_valid = 1'b1;
      tick();
      k++;
    end
    check("drop_reissue",     IMEM_REQ, 1);
    check("drop_addr",        IMEM_ADDR, 7'h40);
    check("drop_early_valid", early_valid, 0);
    wait_pops("drop", 1);
    if (pop_q.size() > 0) begin
      check("drop_pc",    pop_q[0][14:8], 7'h40);
      check("drop_instr", pop_q[0][7:0],  8'hE5);
    end

    // ---- branch with same-cycle RVALID and DEC_READY while buffered ----
    mem_lat = 1;
    do_reset(1'b0);
    k = 0;
    while (!(IMEM_RVALID && INSTR_VALID) && k < 12) begin
      tick();
      k++;
    end
    if (DEPTH == 2) check("brrv_rvalid_seen", IMEM_RVALID && INSTR_VALID, 1);
    DEC_READY = 1'b1;
    branch(7'h20);
    check("brrv_flushed", INSTR_VALID, 0);
    check("brrv_req_low", IMEM_REQ, 0);
    tick();
    check("brrv_req",  IMEM_REQ, 1);
    check("brrv_addr", IMEM_ADDR, 7'h20);
    wait_pops("brrv", 1);
    if (pop_q.size() > 0) begin
      check("brrv_pc",    pop_q[0][14:8], 7'h20);
      check("brrv_instr", pop_q[0][7:0],  8'h85);
    end

    // ---- reset in WAIT, late response after release is ignored ----
    mem_lat = 3;
    do_reset(1'b1);
    wait_accept("rstw");
    mem_en = 1'b0;
    RST_N  = 1'b0;
    #1;
    check("rstw_req",   IMEM_REQ, 0);
    check("rstw_valid", INSTR_VALID, 0);
    tick();
    RST_N       = 1'b1;
    IMEM_RVALID = 1'b1;
    IMEM_RDATA  = 8'h5A;
    pop_q.delete();
    tick();
    check("rstw_valid1", INSTR_VALID, 0);
    check("rstw_req1",   IMEM_REQ, 0);
    tick();
    IMEM_RVALID = 1'b0;
    mem_en      = 1'b1;
    check("rstw_valid2", INSTR_VALID, 0);
    check("rstw_req2",   IMEM_REQ, 1);
    check("rstw_addr2",  IMEM_ADDR, 0);
    wait_pops("rstw", 1);
    if (pop_q.size() > 0) begin
      check("rstw_pc",    pop_q[0][14:8], 0);
      check("rstw_instr", pop_q[0][7:0],  8'hA5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
